// File: rtl/tappy_pkg.sv
// Shared types and byte constants for the PS/2 keycode sequencer.
package tappy_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GOT_E0,
    ST_GOT_F0,
    ST_GOT_E0F0
  } parse_state_t;

  localparam logic [7:0] PFX_EXT = 8'hE0;
  localparam logic [7:0] PFX_BRK = 8'hF0;

  // Device replies (ack, BAT pass, echo, resend, errors) rather than key codes
  localparam logic [7:0] ST_ACK    = 8'hFA;
  localparam logic [7:0] ST_BAT_OK = 8'hAA;
  localparam logic [7:0] ST_ECHO   = 8'hEE;
  localparam logic [7:0] ST_RESEND = 8'hFE;
  localparam logic [7:0] ST_ERR0   = 8'h00;
  localparam logic [7:0] ST_ERR1   = 8'hFF;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic       sys;
  } key_event_t;

  function automatic logic is_status(input logic [7:0] b);
    return b inside {ST_ACK, ST_BAT_OK, ST_ECHO, ST_RESEND, ST_ERR0, ST_ERR1};
  endfunction

endpackage

// File: rtl/key_fifo.sv
// First-word-fall-through event FIFO; drops on full unless a pop frees a slot.
module key_fifo
  import tappy_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       push,
  input  key_event_t push_ev,
  input  logic       pop,
  output key_event_t head,
  output logic       valid,
  output logic       overflow
);

  localparam int AW = $clog2(DEPTH);

  key_event_t      mem [DEPTH];
  logic [AW:0]     wr_ptr, rd_ptr;
  logic            empty, full, do_pop, do_push, drop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;

  assign valid = !empty;
  assign head  = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge sysclk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      if (drop)    overflow <= 1'b1;
    end
  end

  always_ff @(posedge sysclk) begin
    if (!reset && do_push) mem[wr_ptr[AW-1:0]] <= push_ev;
  end

endmodule

// File: rtl/keycode_sequencer.sv
// PS/2 scancode prefix parser (E0/F0) with inter-byte timeout feeding an event FIFO.
module keycode_sequencer
  import tappy_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic [7:0] word,
  input  logic       done,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_brk,
  output logic       key_sys,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       overflow,
  output logic       timeout
);

  localparam int           CW   = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] TERM = CW'(TIMEOUT_CYCLES - 1);

  parse_state_t  state, state_d;
  logic [CW-1:0] idle_cnt, idle_cnt_d;
  logic          push, abort, timeout_q;
  key_event_t    ev, head;
  logic          fifo_valid, fifo_ovf;

  always_comb begin
    state_d = state;
    push    = 1'b0;
    ev      = '0;
    abort   = 1'b0;
    if (done) begin
      unique case (state)
        ST_IDLE: begin
          if (word == PFX_EXT)      state_d = ST_GOT_E0;
          else if (word == PFX_BRK) state_d = ST_GOT_F0;
          else begin
            push = 1'b1;
            ev   = '{code: word, ext: 1'b0, brk: 1'b0, sys: is_status(word)};
          end
        end
        ST_GOT_E0: begin
          if (word == PFX_BRK)      state_d = ST_GOT_E0F0;
          else if (word != PFX_EXT) begin
            state_d = ST_IDLE;
            push    = 1'b1;
            ev      = '{code: word, ext: 1'b1, brk: 1'b0, sys: 1'b0};
          end
        end
        ST_GOT_F0, ST_GOT_E0F0: begin
          // A second prefix after F0 is a protocol error: abandon silently
          state_d = ST_IDLE;
          if (word != PFX_EXT && word != PFX_BRK) begin
            push = 1'b1;
            ev   = '{code: word, ext: (state == ST_GOT_E0F0), brk: 1'b1, sys: 1'b0};
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state != ST_IDLE && idle_cnt == TERM) begin
      state_d = ST_IDLE;
      abort   = 1'b1;
    end
  end

  assign idle_cnt_d = (done || state_d == ST_IDLE) ? '0 : idle_cnt + CW'(1);

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state     <= ST_IDLE;
      idle_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_d;
      idle_cnt  <= idle_cnt_d;
      timeout_q <= abort;
    end
  end

  key_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .sysclk   (sysclk),
    .reset    (reset),
    .push     (push),
    .push_ev  (ev),
    .pop      (key_ready),
    .head     (head),
    .valid    (fifo_valid),
    .overflow (fifo_ovf)
  );

  // Outputs forced low while reset is held, even before the first reset edge
  assign key_valid = fifo_valid & ~reset;
  assign key_code  = reset ? 8'h00 : head.code;
  assign key_ext   = head.ext & ~reset;
  assign key_brk   = head.brk & ~reset;
  assign key_sys   = head.sys & ~reset;
  assign overflow  = fifo_ovf & ~reset;
  assign timeout   = timeout_q & ~reset;

endmodule

// File: tb/tb_keycode_sequencer.sv
// Directed and randomized checks of keycode_sequencer against a queue-based reference model.
module tb_keycode_sequencer;

  localparam int DEPTH = 4;
  localparam int TMO   = 64;

  logic       sysclk = 1'b0;
  logic       reset  = 1'b1;
  logic [7:0] word   = 8'h00;
  logic       done   = 1'b0;
  logic       key_ready = 1'b0;
  logic [7:0] key_code;
  logic       key_ext, key_brk, key_sys, key_valid, overflow, timeout;

  always #5 sysclk = ~sysclk;

  keycode_sequencer #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .sysclk    (sysclk),
    .reset     (reset),
    .word      (word),
    .done      (done),
    .key_code  (key_code),
    .key_ext   (key_ext),
    .key_brk   (key_brk),
    .key_sys   (key_sys),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .overflow  (overflow),
    .timeout   (timeout)
  );

  int checks = 0;
  int errors = 0;
  int tmo_seen = 0;

  // Reference model: prefix flags, age since last byte, event queue {code,ext,brk,sys}
  bit          m_e0, m_f0, m_ovf, m_tmo;
  int          m_age;
  logic [10:0] q[$];

  function automatic bit status_byte(input logic [7:0] b);
    case (b)
      8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_step(input bit r, input bit d, input logic [7:0] w, input bit rdy);
    bit          have_ev, was_full, popping;
    logic [10:0] ev;
    have_ev = 0;
    ev      = '0;
    if (r) begin
      m_e0 = 0; m_f0 = 0; m_ovf = 0; m_tmo = 0; m_age = 0;
      q.delete();
      return;
    end
    m_tmo = 0;
    if (d) begin
      m_age = 0;
      if (!m_e0 && !m_f0) begin
        if (w == 8'hE0)      m_e0 = 1;
        else if (w == 8'hF0) m_f0 = 1;
        else begin have_ev = 1; ev = {w, 1'b0, 1'b0, status_byte(w)}; end
      end else if (m_f0) begin
        if (w != 8'hE0 && w != 8'hF0) begin have_ev = 1; ev = {w, m_e0, 1'b1, 1'b0}; end
        m_e0 = 0; m_f0 = 0;
      end else begin
        if (w == 8'hF0) m_f0 = 1;
        else if (w != 8'hE0) begin have_ev = 1; ev = {w, 1'b1, 1'b0, 1'b0}; m_e0 = 0; end
      end
    end else if (m_e0 || m_f0) begin
      m_age++;
      if (m_age == TMO) begin
        m_e0 = 0; m_f0 = 0; m_age = 0; m_tmo = 1;
      end
    end
    was_full = (q.size() == DEPTH);
    popping  = rdy && (q.size() > 0);
    if (popping) void'(q.pop_front());
    if (have_ev) begin
      if (!was_full || popping) q.push_back(ev);
      else m_ovf = 1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    logic [10:0] h;
    h = (q.size() > 0) ? q[0] : 11'h0;
    chk("cycle_outputs",
        {18'h0, key_valid, key_code, key_ext, key_brk, key_sys, overflow, timeout},
        {18'h0, q.size() > 0, h, m_ovf, m_tmo});
  endtask

  task automatic cycle(input bit r, input bit d, input logic [7:0] w, input bit rdy);
    reset = r; done = d; word = w; key_ready = rdy;
    @(posedge sysclk);
    model_step(r, d, w, rdy);
    #1;
    compare_all();
    if (timeout === 1'b1) tmo_seen++;
  endtask

  task automatic head_is(input string tag, input logic v, input logic [7:0] c,
                         input logic e, input logic b, input logic s);
    chk(tag, {20'h0, key_valid, key_code, key_ext, key_brk, key_sys},
             {20'h0, v, c, e, b, s});
  endtask

  logic [7:0] rw;

  initial begin
    cycle(1, 0, 8'h00, 0);
    cycle(1, 1, 8'h1C, 1);
    chk("reset_state", {25'h0, key_valid, overflow, timeout, key_ext, key_brk, key_sys, 1'b0},
                       32'h0);
    chk("reset_code", {24'h0, key_code}, 32'h0);

    // single make code
    cycle(0, 1, 8'h1C, 0);
    head_is("make_1c", 1, 8'h1C, 0, 0, 0);
    cycle(0, 0, 8'h00, 1);
    head_is("make_1c_drained", 0, 8'h00, 0, 0, 0);

    // extended break E0 F0 75
    cycle(0, 1, 8'hE0, 0);
    cycle(0, 1, 8'hF0, 0);
    head_is("prefix_no_event", 0, 8'h00, 0, 0, 0);
    cycle(0, 1, 8'h75, 0);
    head_is("ext_brk_75", 1, 8'h75, 1, 1, 0);
    cycle(0, 0, 8'h00, 1);
    head_is("ext_brk_single", 0, 8'h00, 0, 0, 0);

    // F0 then abandoned: one timeout pulse, next byte is a plain make
    tmo_seen = 0;
    cycle(0, 1, 8'hF0, 0);
    for (int i = 0; i < TMO + 5; i++) cycle(0, 0, 8'h00, 0);
    chk("timeout_once", tmo_seen, 1);
    cycle(0, 1, 8'h1C, 0);
    head_is("after_timeout", 1, 8'h1C, 0, 0, 0);
    cycle(0, 0, 8'h00, 1);

    // byte arriving exactly on the terminal count wins over the timeout
    tmo_seen = 0;
    cycle(0, 1, 8'hF0, 0);
    for (int i = 0; i < TMO - 1; i++) cycle(0, 0, 8'h00, 0);
    cycle(0, 1, 8'h1C, 0);
    chk("terminal_no_timeout", tmo_seen, 0);
    head_is("terminal_byte_kept", 1, 8'h1C, 0, 1, 0);
    cycle(0, 0, 8'h00, 1);

    // overflow: six bytes into four slots
    for (int i = 0; i < 6; i++) cycle(0, 1, 8'h15 + 8'(i), 0);
    chk("overflow_set", {31'h0, overflow}, 1);
    for (int i = 0; i < 4; i++) begin
      head_is("overflow_order", 1, 8'h15 + 8'(i), 0, 0, 0);
      cycle(0, 0, 8'h00, 1);
    end
    head_is("overflow_drained", 0, 8'h00, 0, 0, 0);
    chk("overflow_sticky", {31'h0, overflow}, 1);

    // full FIFO with simultaneous push and pop
    cycle(1, 0, 8'h00, 0);
    for (int i = 0; i < 4; i++) cycle(0, 1, 8'h21 + 8'(i), 0);
    cycle(0, 1, 8'h25, 1);
    chk("full_pushpop_no_ovf", {31'h0, overflow}, 0);
    for (int i = 0; i < 4; i++) begin
      head_is("full_pushpop_order", 1, 8'h22 + 8'(i), 0, 0, 0);
      cycle(0, 0, 8'h00, 1);
    end
    head_is("full_pushpop_empty", 0, 8'h00, 0, 0, 0);

    // status byte, dangling E0, reset with a coincident byte, then a plain key
    cycle(0, 1, 8'hFA, 0);
    head_is("status_fa", 1, 8'hFA, 0, 0, 1);
    cycle(0, 1, 8'hE0, 0);
    cycle(1, 1, 8'h33, 1);
    head_is("reset_empties", 0, 8'h00, 0, 0, 0);
    cycle(0, 1, 8'h74, 0);
    head_is("prefix_discarded", 1, 8'h74, 0, 0, 0);

    // randomized traffic, dense then sparse bytes to exercise timeouts
    for (int i = 0; i < 1200; i++) begin
      int sel;
      bit d;
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1:    rw = 8'hE0;
        2, 3:    rw = 8'hF0;
        4:       rw = ($urandom_range(0, 1) != 0) ? 8'hFA : 8'hAA;
        default: rw = 8'($urandom);
      endcase
      d = (i < 700) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 39) == 0);
      cycle($urandom_range(0, 199) == 0, d, rw, $urandom_range(0, 2) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/keycode_sequencer.md
KEYCODE_SEQUENCER -- requirements
Module: keycode_sequencer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, number of buffered key events (power of two, 2..16).
REQ-002 Parameter TIMEOUT_CYCLES, default 100000, maximum number of sysclk cycles between the bytes of one multi-byte sequence.
REQ-003 sysclk  input  1  the single system clock; all logic is clocked on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 word  input  8  byte received from the PS/2 receiver, LSB first on the wire; valid only while done is high.
REQ-006 done  input  1  one-cycle pulse marking a new received byte on word.
REQ-007 key_code  output  8  scancode of the head event.
REQ-008 key_ext  output  1  head event was prefixed by 0xE0.
REQ-009 key_brk  output  1  head event is a release (prefixed by 0xF0).
REQ-010 key_sys  output  1  head event is a device status byte, not a key.
REQ-011 key_valid  output  1  the FIFO holds at least one event.
REQ-012 key_ready  input  1  consumer accepts the head event when key_valid and key_ready are both high.
REQ-013 overflow  output  1  sticky flag: at least one event has been dropped.
REQ-014 timeout  output  1  one-cycle pulse when a partial sequence is abandoned.

Function
REQ-015 The parser SHALL have four states: IDLE, GOT_E0, GOT_F0 and GOT_E0F0.
REQ-016 Bytes SHALL be sampled only on cycles where done=1.
REQ-017 IDLE transitions: 0xE0 goes to GOT_E0; 0xF0 goes to GOT_F0; any of 0xFA, 0xAA, 0xEE, 0xFE, 0x00, 0xFF pushes {code, sys=1, ext=0, brk=0} and stays in IDLE; any other byte pushes {code, 0, 0, 0} and stays in IDLE.
REQ-018 GOT_E0 transitions: 0xF0 goes to GOT_E0F0; 0xE0 stays in GOT_E0; any other byte pushes {code, ext=1, brk=0} and returns to IDLE.
REQ-019 GOT_F0 transitions: 0xF0 or 0xE0 is a protocol error that returns to IDLE with no push; any other byte pushes {code, ext=0, brk=1} and returns to IDLE.
REQ-020 GOT_E0F0 transitions: 0xF0 or 0xE0 returns to IDLE with no push; any other byte pushes {code, ext=1, brk=1} and returns to IDLE.
REQ-021 A pushed event SHALL appear at the FIFO outputs, with key_valid=1, on the cycle after the done pulse when the FIFO was previously empty.
REQ-022 The FIFO SHALL be first-word-fall-through: the head event is presented combinationally from storage, and a pop takes effect at the clock edge where key_valid and key_ready are both high.
REQ-023 If the FIFO is full and a push occurs with no pop, the event SHALL be dropped, overflow SHALL be set, and the contents SHALL be unchanged.
REQ-024 If the FIFO is full and a push and a pop occur in the same cycle, both SHALL be accepted, with no overflow and occupancy unchanged.
REQ-025 If the FIFO is empty, key_ready SHALL be ignored and the pointers SHALL stay unchanged.
REQ-026 Read and write pointers SHALL wrap modulo FIFO_DEPTH; an extra occupancy bit distinguishes full from empty.
REQ-027 The idle counter SHALL clear on every done pulse and on every entry to IDLE, and SHALL increment in every non-IDLE state.
REQ-028 When the idle counter reaches TIMEOUT_CYCLES-1, the parser SHALL return to IDLE and pulse timeout for one cycle, with no push.
REQ-029 If a done pulse coincides with the terminal count, the byte SHALL be processed and the timeout SHALL be suppressed.
REQ-030 overflow SHALL clear only on reset.

Reset
REQ-031 While reset=1 the parser SHALL go to IDLE, the FIFO SHALL be emptied, and the idle counter SHALL clear.
REQ-032 During reset, key_valid=0, overflow=0, timeout=0, and key_code/key_ext/key_brk/key_sys=0.
REQ-033 Reset SHALL override a simultaneous done pulse or pop; the byte is discarded.
REQ-034 Reset asserted mid-sequence SHALL discard the partial prefix state.

Structure
REQ-035 A shared package tappy_pkg SHALL hold the parser state enum, the prefix constants 0xE0 and 0xF0, the status-byte constants, and the packed key-event type {code[7:0], ext, brk, sys}.
REQ-036 The FIFO SHALL be a sub-module key_fifo, parameterised by FIFO_DEPTH and carrying the packed key-event type.

Verification
REQ-037 Byte 0x1C, done pulsed, key_ready=0 -> next cycle key_valid=1, key_code=0x1C, ext=0, brk=0, sys=0.
REQ-038 Bytes E0,F0,75 -> exactly one event: code=0x75, ext=1, brk=1; no event is produced for the prefixes.
REQ-039 Byte F0, then 100000 idle cycles, then byte 1C -> timeout pulses once; the event is {0x1C, brk=0}.
REQ-040 Six key bytes with key_ready=0 (FIFO_DEPTH=4) -> four events retained in order, overflow=1 and sticky; draining yields the first four codes.
REQ-041 FIFO full, with push and pop in the same cycle -> overflow stays 0, occupancy stays 4, and the new event lands at the tail.
REQ-042 Bytes FA then E0, then reset for one cycle, then byte 74 -> FIFO empty after reset; the event is {0x74, ext=0}.
